// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder
//   Burst memory responder for a cache bus master. A request is captured in
//   IDLE, held for LATENCY idle cycles, then served as len+1 consecutive
//   beats from/to an internal DEPTH_WORDS x 64-bit memory.
//
// Parameters
//   DEPTH_WORDS : number of 64-bit memory words (power of two, >= 16)
//   LATENCY     : idle cycles between capture and the first beat (0..15)
//
// Ports
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high reset (memory contents are kept)
//   creq  : burst request (valid, is_write, size, addr, strobe, data, len, burst)
//   cresp : registered burst response (ready, last, data)

`ifndef CBUS_TYPES_SV
`define CBUS_TYPES_SV
typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
} cbus_burst_e;

typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    cbus_burst_e burst;
} cbus_req_t;

typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
} cbus_resp_t;
`endif

module cbus_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [4:0]  LAT5 = 5'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST
    } state_e;

    state_e          state_q;
    logic            is_write_q;
    logic [2:0]      size_q;
    logic [7:0]      len_q;
    cbus_burst_e     burst_q;
    logic [63:0]     addr_q;      // address of the next beat to issue
    logic [AW-1:0]   wr_idx_q;    // word index of the beat currently presented
    logic [7:0]      cnt_q;       // beats issued so far
    logic [3:0]      lat_q;
    logic            ready_q;
    logic            last_q;
    logic [63:0]     data_q;

    logic [63:0]     mem [DEPTH_WORDS];

    logic [63:0]     step;
    logic [63:0]     wrap_mask;
    logic [63:0]     incr_addr;
    logic [63:0]     next_addr_d;
    logic [AW-1:0]   rd_idx;
    logic            commit;

    // Beat address sequencing from the captured burst parameters.
    always_comb begin
        step        = 64'd1 << size_q;
        wrap_mask   = ((({56'd0, len_q}) + 64'd1) << size_q) - 64'd1;
        incr_addr   = addr_q + step;
        next_addr_d = incr_addr;
        case (burst_q)
            BURST_FIXED: next_addr_d = addr_q;
            // Stay inside the window aligned to (len+1)*(1<<size) bytes.
            BURST_WRAP:  next_addr_d = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr_d = incr_addr;
        endcase
    end

    // Out-of-range addresses alias by simply dropping the upper bits.
    assign rd_idx = addr_q[AW+2:3];

    // A write beat commits at the edge ending its ready cycle, and only if
    // the master still holds valid and no reset is pending.
    assign commit = !reset && ready_q && is_write_q && creq.valid;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (creq.strobe[b]) begin
                    mem[wr_idx_q][8*b +: 8] <= creq.data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (creq.valid) begin
                        is_write_q <= creq.is_write;
                        size_q     <= creq.size;
                        addr_q     <= creq.addr;
                        len_q      <= creq.len;
                        burst_q    <= creq.burst;
                        cnt_q      <= '0;
                        lat_q      <= '0;
                        state_q    <= (LATENCY == 0) ? S_BURST : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!creq.valid) begin
                        state_q <= S_IDLE;
                    end else if (({1'b0, lat_q} + 5'd1) == LAT5) begin
                        state_q <= S_BURST;
                    end else begin
                        lat_q <= lat_q + 4'd1;
                    end
                end
                S_BURST: begin
                    // The state stays BURST through the last ready cycle so
                    // a request presented right after it is seen in IDLE.
                    if (!creq.valid || (ready_q && last_q)) begin
                        state_q <= S_IDLE;
                    end else begin
                        ready_q  <= 1'b1;
                        last_q   <= (cnt_q == len_q);
                        data_q   <= is_write_q ? 64'd0 : mem[rd_idx];
                        wr_idx_q <= rd_idx;
                        addr_q   <= next_addr_d;
                        cnt_q    <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cresp.ready = ready_q;
    assign cresp.last  = last_q;
    assign cresp.data  = data_q;

endmodule

// File: tb/tb_cbus_mem_responder.sv
// tb_cbus_mem_responder
//   Directed bench for cbus_mem_responder (LATENCY=2, DEPTH_WORDS=1024).
//   A table of transactions is played through run_txn, followed by the
//   abort and reset-during-burst sequences.

module tb_cbus_mem_responder;

    localparam int LAT = 2;

    logic       clk;
    logic       reset;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    int nchecks = 0;
    int nerrors = 0;

    cbus_mem_responder #(
        .DEPTH_WORDS(1024),
        .LATENCY    (LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .creq (creq),
        .cresp(cresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1);
    end

    // One transaction: for writes x[] is the data per beat, for reads it is
    // the expected data per beat. b2b chains the next one with no idle cycle.
    typedef struct {
        logic              wr;
        logic [2:0]        size;
        logic [63:0]       addr;
        logic [7:0]        len;
        cbus_burst_e       burst;
        logic [7:0]        strb;
        logic [3:0][63:0]  x;
        logic              b2b;
    } vec_t;

    vec_t tv[16];

    function automatic vec_t mk(logic wr, logic [2:0] sz, logic [63:0] a, logic [7:0] len,
                                cbus_burst_e bt, logic [7:0] st, logic [63:0] x0,
                                logic [63:0] x1, logic [63:0] x2, logic [63:0] x3, logic b2b);
        vec_t v;
        v.wr = wr; v.size = sz; v.addr = a; v.len = len; v.burst = bt; v.strb = st;
        v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3; v.b2b = b2b;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input vec_t v);
        creq.valid    = 1'b1;
        creq.is_write = v.wr;
        creq.size     = v.size;
        creq.addr     = v.addr;
        creq.len      = v.len;
        creq.burst    = v.burst;
        creq.strobe   = v.strb;
        creq.data     = v.x[0];
    endtask

    // Called right after the capture edge; counts edges until the first beat.
    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        while (!cresp.ready && k < 20) begin
            tick();
            k++;
        end
        chk({nm, " latency"}, 64'(k), 64'(LAT + 1));
    endtask

    task automatic run_txn(input string nm, input vec_t v);
        issue(v);
        tick();
        chk({nm, " no early ready"}, {63'd0, cresp.ready}, 64'd0);
        wait_ready(nm);
        if (!cresp.ready) begin
            creq.valid = 1'b0;
            tick();
            return;
        end
        for (int b = 0; b <= int'(v.len); b++) begin
            creq.data = v.x[b[1:0]];
            chk($sformatf("%s beat%0d ready", nm, b), {63'd0, cresp.ready}, 64'd1);
            chk($sformatf("%s beat%0d last", nm, b), {63'd0, cresp.last},
                (b == int'(v.len)) ? 64'd1 : 64'd0);
            chk($sformatf("%s beat%0d data", nm, b), cresp.data, v.wr ? 64'd0 : v.x[b[1:0]]);
            tick();
        end
        chk({nm, " ready after last"}, {63'd0, cresp.ready}, 64'd0);
        if (!v.b2b) begin
            creq.valid = 1'b0;
            tick();
        end
    endtask

    initial begin
        vec_t v;

        tv[0]  = mk(1, 3, 64'h80,   0, BURST_INCR,  8'hFF, 64'h1122334455667788, 0, 0, 0, 0);
        tv[1]  = mk(0, 3, 64'h80,   0, BURST_INCR,  8'h00, 64'h1122334455667788, 0, 0, 0, 0);
        tv[2]  = mk(1, 3, 64'h100,  3, BURST_INCR,  8'hFF, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 0);
        tv[3]  = mk(0, 3, 64'h100,  3, BURST_INCR,  8'h00, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 0);
        tv[4]  = mk(1, 3, 64'h100,  3, BURST_INCR,  8'hFF, 0, 1, 2, 3, 1);
        tv[5]  = mk(0, 3, 64'h110,  3, BURST_WRAP,  8'h00, 2, 3, 0, 1, 0);
        tv[6]  = mk(1, 3, 64'h40,   0, BURST_INCR,  8'hFF, 64'hFFFFFFFFFFFFFFFF, 0, 0, 0, 0);
        tv[7]  = mk(1, 3, 64'h40,   0, BURST_INCR,  8'h0F, 0, 0, 0, 0, 0);
        tv[8]  = mk(0, 3, 64'h40,   0, BURST_INCR,  8'h00, 64'hFFFFFFFF00000000, 0, 0, 0, 0);
        tv[9]  = mk(1, 3, 64'h40,   0, BURST_INCR,  8'h00, 64'h1234, 0, 0, 0, 0);
        tv[10] = mk(0, 3, 64'h40,   0, BURST_INCR,  8'h00, 64'hFFFFFFFF00000000, 0, 0, 0, 0);
        tv[11] = mk(1, 3, 64'h200,  2, BURST_FIXED, 8'hFF, 64'h11, 64'h22, 64'h33, 0, 0);
        tv[12] = mk(0, 3, 64'h200,  1, BURST_FIXED, 8'h00, 64'h33, 64'h33, 0, 0, 1);
        tv[13] = mk(0, 3, 64'h2080, 0, BURST_INCR,  8'h00, 64'h1122334455667788, 0, 0, 0, 0);
        tv[14] = mk(0, 3, 64'h100,  1, BURST_RSVD,  8'h00, 0, 1, 0, 0, 0);
        tv[15] = mk(0, 2, 64'h100,  3, BURST_INCR,  8'h00, 0, 0, 1, 1, 0);

        // Reset state, including a valid request held during reset.
        reset = 1'b1;
        creq  = '0;
        tick();
        tick();
        chk("reset ready", {63'd0, cresp.ready}, 64'd0);
        chk("reset last",  {63'd0, cresp.last},  64'd0);
        chk("reset data",  cresp.data,           64'd0);
        issue(tv[1]);
        tick();
        tick();
        chk("reset prio ready", {63'd0, cresp.ready}, 64'd0);
        creq.valid = 1'b0;
        reset = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            run_txn($sformatf("v%0d", i), tv[i]);
        end

        // Abort an 8-beat read by dropping valid during beat 3.
        v = mk(0, 3, 64'h100, 7, BURST_INCR, 8'h00, 0, 1, 2, 3, 0);
        issue(v);
        tick();
        wait_ready("abort rd");
        chk("abort rd beat1", cresp.data, 64'd0);
        tick();
        chk("abort rd beat2 ready", {63'd0, cresp.ready}, 64'd1);
        chk("abort rd beat2", cresp.data, 64'd1);
        tick();
        chk("abort rd beat3", cresp.data, 64'd2);
        creq.valid = 1'b0;
        tick();
        chk("abort rd no beat", {63'd0, cresp.ready}, 64'd0);
        run_txn("after abort", tv[1]);

        // Abort a write: beat 3 presented with valid low must not commit.
        run_txn("fill 300", mk(1, 3, 64'h300, 3, BURST_INCR, 8'hFF, 64'hEE, 64'hEE, 64'hEE, 64'hEE, 0));
        v = mk(1, 3, 64'h300, 3, BURST_INCR, 8'hFF, 1, 2, 3, 4, 0);
        issue(v);
        tick();
        wait_ready("abort wr");
        creq.data = 64'd1;
        tick();
        creq.data = 64'd2;
        tick();
        creq.data  = 64'd3;
        creq.valid = 1'b0;
        tick();
        chk("abort wr no beat", {63'd0, cresp.ready}, 64'd0);
        run_txn("abort wr rb", mk(0, 3, 64'h300, 3, BURST_INCR, 8'h00, 1, 2, 64'hEE, 64'hEE, 0));

        // Reset during beat 3 of a 4-beat write.
        run_txn("fill 400", mk(1, 3, 64'h400, 3, BURST_INCR, 8'hFF, 64'h55, 64'h55, 64'h55, 64'h55, 0));
        v = mk(1, 3, 64'h400, 3, BURST_INCR, 8'hFF, 64'hB1, 64'hB2, 64'hB3, 64'hB4, 0);
        issue(v);
        tick();
        wait_ready("rst wr");
        creq.data = 64'hB1;
        tick();
        creq.data = 64'hB2;
        tick();
        creq.data = 64'hB3;
        reset = 1'b1;
        tick();
        chk("rst wr ready", {63'd0, cresp.ready}, 64'd0);
        chk("rst wr last",  {63'd0, cresp.last},  64'd0);
        chk("rst wr data",  cresp.data,           64'd0);
        reset = 1'b0;
        // Request presented in the first cycle after reset release.
        run_txn("rst wr rb", mk(0, 3, 64'h400, 3, BURST_INCR, 8'h00, 64'hB1, 64'hB2, 64'h55, 64'h55, 0));

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
